// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding and frame timing helper.
// Used by the TX arbiter and reusable by the UART TX/RX blocks.
// A UART byte slot is 10 frame bits plus a guard bit.
package uart_pkg;

    localparam int UART_FRAME_BITS = 10;
    localparam int UART_GUARD_BITS = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2,
        HOLD  = 2'd3
    } arb_state_t;

    // Byte slot length in clocks, given bit time = CLK_FREQ/BAUD.
    function automatic int byte_cycles(input int bit_cycles);
        return bit_cycles * (UART_FRAME_BITS + UART_GUARD_BITS);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte bus plus transmitter byte/strobe bus for the UART TX arbiter.
// master = requester/transmitter environment, slave = arbiter.
// req is held until ack; command_in_flag is a single-cycle strobe.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   ack;
    logic [7:0]         command_in;
    logic               command_in_flag;

    modport master (
        output req, req_data, req_last,
        input  ack, command_in, command_in_flag
    );

    modport slave (
        input  req, req_data, req_last,
        output ack, command_in, command_in_flag
    );
endinterface

// File: rtl/rr_pick.sv
// Round-robin selector: first set request at or after ptr_i, wrapping mod N_REQ.
// Latency: purely combinational.
// Backpressure: none; vld_o low when no request is set.
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [2:0]       ptr_i,
    output logic [2:0]       idx_o,
    output logic             vld_o
);

    int j;

    // Scan from farthest to nearest so the closest-to-pointer request wins.
    always_comb begin
        idx_o = 3'd0;
        vld_o = 1'b0;
        j     = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % N_REQ;
            if (req_i[j]) begin
                idx_o = 3'(j);
                vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ requesters, round-robin per message.
// Latency: req seen in IDLE -> strobe/ack next cycle; strobes BYTE_CYCLES+1 apart.
// Backpressure: requesters hold req until ack; a locked owner blocks others until last byte or timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_arbiter_if.slave   bus,
    output logic               busy,
    output logic [2:0]         owner
);

    localparam int BIT_CYCLES  = CLK_FREQ / BAUD;
    localparam int BYTE_CYCLES = byte_cycles(BIT_CYCLES);
    localparam int GAP_W       = $clog2(BYTE_CYCLES);
    localparam int TO_W        = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    arb_state_t         state_q;
    logic [2:0]         ptr_q;
    logic [2:0]         owner_q;
    logic               lock_q;
    logic [GAP_W-1:0]   gap_q;
    logic [TO_W-1:0]    to_q;
    logic [N_REQ-1:0]   ack_q;
    logic [7:0]         cmd_q;
    logic               flag_q;
    logic               busy_q;

    logic [2:0]         pick_idx;
    logic               pick_vld;
    logic [2:0]         sel_idx;
    logic [7:0]         sel_data;
    logic               sel_last;
    logic               own_req;
    logic               issue_go;
    logic [2:0]         ptr_d;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .idx_o (pick_idx),
        .vld_o (pick_vld)
    );

    // HOLD reissues to the locked owner; IDLE issues to the round-robin pick.
    always_comb begin
        sel_idx  = (state_q == HOLD) ? owner_q : pick_idx;
        sel_data = 8'h00;
        sel_last = 1'b0;
        own_req  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel_idx == 3'(i)) begin
                sel_data = bus.req_data[8*i +: 8];
                sel_last = bus.req_last[i];
            end
            if (owner_q == 3'(i)) begin
                own_req = bus.req[i];
            end
        end
        issue_go = ((state_q == IDLE) && pick_vld) || ((state_q == HOLD) && own_req);
        ptr_d    = (owner_q == 3'(N_REQ - 1)) ? 3'd0 : owner_q + 3'd1;
    end

    // Arbitration FSM with registered strobe, ack, byte, busy and owner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            owner_q <= 3'd0;
            lock_q  <= 1'b0;
            gap_q   <= '0;
            to_q    <= '0;
            ack_q   <= '0;
            cmd_q   <= 8'h00;
            flag_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ack_q  <= '0;
            flag_q <= 1'b0;
            case (state_q)
                IDLE, HOLD: begin
                    if (issue_go) begin
                        owner_q <= sel_idx;
                        ack_q   <= ONE << sel_idx;
                        cmd_q   <= sel_data;
                        flag_q  <= 1'b1;
                        lock_q  <= ~sel_last;
                        gap_q   <= GAP_W'(BYTE_CYCLES - 1);
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end else if (state_q == HOLD) begin
                        if (to_q == TO_W'(LOCK_TIMEOUT - 1)) begin
                            lock_q  <= 1'b0;
                            ptr_q   <= ptr_d;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            to_q <= to_q + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    gap_q   <= gap_q - 1'b1;
                    state_q <= GAP;
                end
                GAP: begin
                    if (gap_q == '0) begin
                        if (lock_q) begin
                            to_q    <= '0;
                            state_q <= HOLD;
                        end else begin
                            ptr_q   <= ptr_d;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ack             = ack_q;
    assign bus.command_in      = cmd_q;
    assign bus.command_in_flag = flag_q;
    assign busy                = busy_q;
    assign owner               = owner_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with 1 kHz clock / 100 baud: 110-cycle byte slots,
// lock timeout 50 cycles, four requesters. Plus a few standalone rr_pick vectors.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter_if #(.N_REQ(4)) bus ();
    logic       busy;
    logic [2:0] owner;

    uart_tx_arbiter #(
        .N_REQ(4), .CLK_FREQ(1000), .BAUD(100), .LOCK_TIMEOUT(50)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .owner(owner)
    );

    logic [3:0] pk_req;
    logic [2:0] pk_ptr;
    logic [2:0] pk_idx;
    logic       pk_vld;

    rr_pick #(.N_REQ(4)) u_pick (
        .req_i(pk_req), .ptr_i(pk_ptr), .idx_o(pk_idx), .vld_o(pk_vld)
    );

    task automatic do_reset();
        rst          = 1'b0;
        bus.req      = '0;
        bus.req_data = '0;
        bus.req_last = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic set_byte(input int i, input logic [7:0] d, input logic last);
        bus.req[i]            = 1'b1;
        bus.req_data[8*i +: 8] = d;
        bus.req_last[i]       = last;
    endtask

    // Advance negedge by negedge until a strobe is seen or the bound runs out.
    task automatic wait_strobe(input int bound, output bit got, output int c,
                               output logic [7:0] d, output logic [3:0] a, output logic [2:0] o);
        got = 1'b0; c = 0; d = 8'h00; a = 4'h0; o = 3'd0;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge clk);
            if (bus.command_in_flag) begin
                got = 1'b1; c = cyc; d = bus.command_in; a = bus.ack; o = owner;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; bus.req = '0; bus.req_data = '0; bus.req_last = '0;
        repeat (2) @(negedge clk);
        total++; if (bus.ack !== 4'h0) begin bad++; $display("FAIL reset_ack got=%b exp=0000", bus.ack); end
        total++; if (bus.command_in !== 8'h00) begin bad++; $display("FAIL reset_cmd got=%h exp=00", bus.command_in); end
        total++; if (bus.command_in_flag !== 1'b0) begin bad++; $display("FAIL reset_flag got=%b exp=0", bus.command_in_flag); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (owner !== 3'd0) begin bad++; $display("FAIL reset_owner got=%0d exp=0", owner); end
    endtask

    task automatic test_single();
        bit got; int c; int c0; logic [7:0] d; logic [3:0] a; logic [2:0] o;
        do_reset();
        c0 = cyc;
        set_byte(2, 8'hA5, 1'b1);
        wait_strobe(20, got, c, d, a, o);
        total++; if (!got || c !== c0 + 1) begin bad++; $display("FAIL single_lat got=%0d exp=%0d", c - c0, 1); end
        total++; if (d !== 8'hA5) begin bad++; $display("FAIL single_data got=%h exp=a5", d); end
        total++; if (a !== 4'b0100) begin bad++; $display("FAIL single_ack got=%b exp=0100", a); end
        total++; if (o !== 3'd2) begin bad++; $display("FAIL single_owner got=%0d exp=2", o); end
        bus.req[2] = 1'b0;
        @(negedge clk);
        total++; if (bus.command_in_flag !== 1'b0 || bus.ack !== 4'h0) begin bad++; $display("FAIL single_pulse got=%b/%b exp=0/0000", bus.command_in_flag, bus.ack); end
        repeat (108) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_end got=%b exp=1", busy); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b exp=0", busy); end
        total++; if (bus.command_in !== 8'hA5) begin bad++; $display("FAIL single_hold got=%h exp=a5", bus.command_in); end
    endtask

    task automatic test_fairness();
        bit got; int c; int c0; int prev; logic [7:0] d; logic [3:0] a; logic [2:0] o;
        logic [7:0] exp_d; logic [3:0] exp_a;
        do_reset();
        c0 = cyc; prev = 0;
        for (int i = 0; i < 4; i++) set_byte(i, 8'hB0 + 8'(i), 1'b1);
        for (int k = 0; k < 5; k++) begin
            wait_strobe(200, got, c, d, a, o);
            exp_d = 8'hB0 + 8'(k % 4);
            exp_a = 4'b0001 << (k % 4);
            total++; if (!got || a !== exp_a) begin bad++; $display("FAIL fair_ack[%0d] got=%b exp=%b", k, a, exp_a); end
            total++; if (d !== exp_d) begin bad++; $display("FAIL fair_data[%0d] got=%h exp=%h", k, d, exp_d); end
            if (k == 0) begin
                total++; if (c !== c0 + 1) begin bad++; $display("FAIL fair_lat got=%0d exp=1", c - c0); end
            end else begin
                total++; if (c - prev !== 111) begin bad++; $display("FAIL fair_gap[%0d] got=%0d exp=111", k, c - prev); end
            end
            prev = c;
        end
        bus.req = '0;
    endtask

    task automatic test_lock();
        bit got; int c; int s1; logic [7:0] d; logic [3:0] a; logic [2:0] o;
        do_reset();
        set_byte(0, 8'h11, 1'b0);
        set_byte(1, 8'h44, 1'b1);
        wait_strobe(20, got, s1, d, a, o);
        total++; if (!got || d !== 8'h11 || a !== 4'b0001) begin bad++; $display("FAIL lock_first got=%h/%b exp=11/0001", d, a); end
        set_byte(0, 8'h22, 1'b1);
        wait_strobe(200, got, c, d, a, o);
        total++; if (!got || d !== 8'h22 || a !== 4'b0001) begin bad++; $display("FAIL lock_second got=%h/%b exp=22/0001", d, a); end
        total++; if (c - s1 !== 111) begin bad++; $display("FAIL lock_gap got=%0d exp=111", c - s1); end
        bus.req[0] = 1'b0; s1 = c;
        wait_strobe(200, got, c, d, a, o);
        total++; if (!got || d !== 8'h44 || a !== 4'b0010) begin bad++; $display("FAIL lock_next got=%h/%b exp=44/0010", d, a); end
        total++; if (c - s1 !== 111) begin bad++; $display("FAIL lock_next_gap got=%0d exp=111", c - s1); end
        bus.req = '0;
    endtask

    task automatic test_timeout();
        bit got; int c; int s1; logic [7:0] d; logic [3:0] a; logic [2:0] o;
        do_reset();
        set_byte(0, 8'h33, 1'b0);
        set_byte(3, 8'h77, 1'b1);
        wait_strobe(20, got, s1, d, a, o);
        total++; if (!got || d !== 8'h33 || a !== 4'b0001) begin bad++; $display("FAIL tmo_first got=%h/%b exp=33/0001", d, a); end
        bus.req[0] = 1'b0;
        repeat (159) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL tmo_hold_busy got=%b exp=1", busy); end
        total++; if (bus.command_in_flag !== 1'b0) begin bad++; $display("FAIL tmo_hold_flag got=%b exp=0", bus.command_in_flag); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL tmo_release got=%b exp=0", busy); end
        wait_strobe(20, got, c, d, a, o);
        total++; if (!got || c - s1 !== 161) begin bad++; $display("FAIL tmo_lat got=%0d exp=161", c - s1); end
        total++; if (d !== 8'h77 || a !== 4'b1000 || o !== 3'd3) begin bad++; $display("FAIL tmo_grant got=%h/%b/%0d exp=77/1000/3", d, a, o); end
        bus.req = '0;
    endtask

    task automatic test_reset_mid_gap();
        bit got; int c; int s1; int r; logic [7:0] d; logic [3:0] a; logic [2:0] o;
        do_reset();
        set_byte(2, 8'h55, 1'b1);
        wait_strobe(20, got, s1, d, a, o);
        total++; if (!got || a !== 4'b0100) begin bad++; $display("FAIL mid_first got=%b exp=0100", a); end
        bus.req[2] = 1'b0;
        set_byte(1, 8'h66, 1'b1);
        set_byte(3, 8'h77, 1'b1);
        repeat (41) @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (bus.command_in !== 8'h00 || bus.command_in_flag !== 1'b0) begin bad++; $display("FAIL mid_rst_cmd got=%h/%b exp=00/0", bus.command_in, bus.command_in_flag); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
        total++; if (owner !== 3'd0 || bus.ack !== 4'h0) begin bad++; $display("FAIL mid_rst_owner got=%0d/%b exp=0/0000", owner, bus.ack); end
        repeat (2) @(negedge clk);
        rst = 1'b1; r = cyc;
        wait_strobe(20, got, c, d, a, o);
        total++; if (!got || c !== r + 1) begin bad++; $display("FAIL mid_lat got=%0d exp=1", c - r); end
        total++; if (a !== 4'b0010 || d !== 8'h66) begin bad++; $display("FAIL mid_ptr got=%b/%h exp=0010/66", a, d); end
        bus.req = '0;
    endtask

    task automatic test_withdraw();
        bit got; int c; int s1; int n_strobe; int n_ack2; logic [7:0] d; logic [3:0] a; logic [2:0] o;
        do_reset();
        set_byte(0, 8'h88, 1'b1);
        wait_strobe(20, got, s1, d, a, o);
        total++; if (!got || a !== 4'b0001) begin bad++; $display("FAIL wd_first got=%b exp=0001", a); end
        bus.req[0] = 1'b0;
        repeat (20) @(negedge clk);
        set_byte(2, 8'h99, 1'b1);
        @(negedge clk);
        bus.req[2] = 1'b0;
        n_strobe = 0; n_ack2 = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.command_in_flag) n_strobe++;
            if (bus.ack[2]) n_ack2++;
        end
        total++; if (n_strobe !== 0) begin bad++; $display("FAIL wd_strobe got=%0d exp=0", n_strobe); end
        total++; if (n_ack2 !== 0) begin bad++; $display("FAIL wd_ack2 got=%0d exp=0", n_ack2); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wd_idle got=%b exp=0", busy); end
    endtask

    task automatic test_rr_pick();
        logic [3:0] t_req [5] = '{4'b1010, 4'b1010, 4'b0001, 4'b1111, 4'b0000};
        logic [2:0] t_ptr [5] = '{3'd2,    3'd0,    3'd3,    3'd1,    3'd2};
        logic [2:0] t_idx [5] = '{3'd3,    3'd1,    3'd0,    3'd1,    3'd0};
        logic       t_vld [5] = '{1'b1,    1'b1,    1'b1,    1'b1,    1'b0};
        for (int i = 0; i < 5; i++) begin
            pk_req = t_req[i]; pk_ptr = t_ptr[i];
            #1;
            total++; if (pk_vld !== t_vld[i]) begin bad++; $display("FAIL pick_vld[%0d] got=%b exp=%b", i, pk_vld, t_vld[i]); end
            if (t_vld[i]) begin
                total++; if (pk_idx !== t_idx[i]) begin bad++; $display("FAIL pick_idx[%0d] got=%0d exp=%0d", i, pk_idx, t_idx[i]); end
            end
        end
    endtask

    initial begin
        pk_req = '0; pk_ptr = '0;
        test_reset();
        test_rr_pick();
        test_single();
        test_fairness();
        test_lock();
        test_timeout();
        test_reset_mid_gap();
        test_withdraw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single on-board UART feedback transmitter (byte + one-cycle flag interface) between N_REQ requesters: command decoder echo, video-channel status, frame-buffer error report, and so on.
- Round-robin grant per message, byte pacing from a byte-time counter (the transmitter has no busy output), and optional multi-byte message locking.
- Sits between the status sources and the command_in / command_in_flag inputs of the UART command block.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- CLK_FREQ, 50_000_000, clk frequency in Hz.
- BAUD, 115200, UART baud rate.
- LOCK_TIMEOUT, 65535, cycles a locked owner may idle between bytes before the lock is forcibly released.
- Derived localparam BIT_CYCLES = CLK_FREQ/BAUD (integer division).
- Derived localparam BYTE_CYCLES = BIT_CYCLES*11, which is 10 frame bits plus 1 guard bit.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- req  input  N_REQ  per-requester byte-valid; held high until acked.
- req_data  input  8*N_REQ  byte of requester i at [8i+7:8i].
- req_last  input  N_REQ  1 = this byte ends the requester's message.
- ack  output  N_REQ  one-cycle pulse: byte of requester i taken.
- command_in  output  8  byte to transmitter.
- command_in_flag  output  1  one-cycle transmit strobe.
- busy  output  1  high whenever state != IDLE.
- owner  output  3  index of the current/last granted requester.

Behaviour:
- Reset (rst low, asynchronous) forces the following, regardless of the current state; a byte already on the line is abandoned:
  - ack=0, command_in=8'h00, command_in_flag=0, busy=0, owner=0.
  - Round-robin pointer = 0, state=IDLE, counters=0, lock=0.
- States:
  - IDLE: if any req is high, select the first requester at or after the pointer, wrapping modulo N_REQ. Set owner = that index, go to ISSUE.
  - ISSUE (exactly 1 cycle): command_in=req_data[owner], command_in_flag=1, ack[owner]=1. Set lock = ~req_last[owner]. Load gap counter = BYTE_CYCLES-1. Go to GAP.
  - GAP: decrement the gap counter each cycle. At 0:
    - If lock=1, go to HOLD with the timeout counter cleared.
    - Else set pointer = owner+1 (wrapping) and go to IDLE.
  - HOLD, locked and waiting for the owner's next byte:
    - If req[owner]=1, go to ISSUE with the same owner; other requesters are ignored.
    - Else increment the timeout counter. When it reaches LOCK_TIMEOUT, clear lock, set pointer = owner+1, go to IDLE.
- Latency and spacing:
  - req rising in IDLE at cycle T gives command_in_flag and ack at T+1.
  - Consecutive strobes are exactly BYTE_CYCLES+1 cycles apart when the next request is already pending, because IDLE/HOLD consumes one cycle.
- Outputs:
  - ack and command_in_flag are registered and coincide, and are never high outside ISSUE.
  - command_in holds its last value after ISSUE; it is not cleared.
- Simultaneous requests: grant follows strict rotation from the pointer. A requester that was just served has lowest priority at the next arbitration.
- Request withdrawal: a req dropped before ack is legal. Arbitration uses only the req value sampled in IDLE/HOLD, so no byte is issued for a withdrawn req.
- Lock scope: while lock=1 no other requester can be granted, even if the owner's later bytes arrive slowly, up to LOCK_TIMEOUT.
- Counter widths: gap counter $clog2(BYTE_CYCLES); timeout counter $clog2(LOCK_TIMEOUT+1).
- The pointer wraps from N_REQ-1 to 0, including for non-power-of-2 N_REQ.

Decomposition:
- Shared package uart_pkg:
  - state encoding enum {IDLE, ISSUE, GAP, HOLD}.
  - function computing BYTE_CYCLES from CLK_FREQ/BAUD, reused by the UART TX/RX blocks.
  - UART_GUARD_BITS=1.
- One natural sub-module: rr_pick. A combinational round-robin selector that takes the req vector and pointer and returns a grant index plus a valid flag. It is unit-tested standalone.

Test Plan (CLK_FREQ=1000, BAUD=100, so BIT_CYCLES=10 and BYTE_CYCLES=110; LOCK_TIMEOUT=50; N_REQ=4):
- Single byte: req[2]=1, data 8'hA5, last=1 at cycle 10 -> flag and ack[2] at cycle 11 with command_in=8'hA5, owner=2; busy high cycles 11..120; IDLE at 121.
- Fairness: req=4'b1111 held and all last=1 -> grant order 0,1,2,3,0; strobes spaced exactly 111 cycles.
- Lock: req0 sends 8'h11 (last=0) then 8'h22 (last=1) while req1 is pending -> strobes 11, 22, then req1's byte; req1 never interleaved.
- Lock timeout: req0 sends 8'h33 (last=0) then drops req; req3 is pending -> lock released 50 cycles after entering HOLD; req3's byte strobed one cycle after return to IDLE.
- Reset mid-GAP: assert rst at 40 cycles into GAP -> all outputs 0 immediately; after release, a pending req1 strobes one cycle after first IDLE sampling; pointer starts at 0.
- Withdrawal: req2 pulses for 1 cycle while in GAP -> no ack[2], no strobe for requester 2.
